// File: rtl/sys_cmd_framer.sv
// Host-side command framer: serialises one register/ALU command into the controller's
// byte frame over a valid/ready stream, then gathers the response or reports a timeout.
module sys_cmd_framer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4,
   parameter int TIMEOUT    = 1024,
   parameter int TO_WIDTH   = 11
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_type,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_data,
   input  logic [DATA_WIDTH-1:0]   cmd_opa,
   input  logic [DATA_WIDTH-1:0]   cmd_opb,
   input  logic [FUN_WIDTH-1:0]    cmd_fun,
   output logic [7:0]              byte_out,
   output logic                    byte_valid,
   input  logic                    byte_ready,
   input  logic                    rsp_valid,
   input  logic [7:0]              rsp_byte,
   output logic [2*DATA_WIDTH-1:0] rsp_data,
   output logic                    rsp_done,
   output logic                    rsp_timeout,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

   localparam logic [1:0] T_WR  = 2'd0;
   localparam logic [1:0] T_RD  = 2'd1;
   localparam logic [1:0] T_ALU = 2'd2;

   state_t                  state;
   logic [1:0]              cap_type;
   logic [ADDR_WIDTH-1:0]   cap_addr;
   logic [DATA_WIDTH-1:0]   cap_data;
   logic [DATA_WIDTH-1:0]   cap_opa;
   logic [DATA_WIDTH-1:0]   cap_opb;
   logic [FUN_WIDTH-1:0]    cap_fun;
   logic [1:0]              idx;
   logic [1:0]              next_idx;
   logic [1:0]              last_idx;
   logic [7:0]              next_byte;
   logic                    rsp_cnt;
   logic [TO_WIDTH-1:0]     to_cnt;

   function automatic logic [7:0] header(input logic [1:0] t);
      case (t)
         T_WR:    header = 8'hAA;
         T_RD:    header = 8'hBB;
         T_ALU:   header = 8'hCC;
         default: header = 8'hDD;
      endcase
   endfunction

   // The byte that follows the current one, taken from the captured command fields.
   always_comb begin
      next_idx  = idx + 2'd1;
      next_byte = 8'h00;
      last_idx  = 2'd1;
      case (cap_type)
         T_WR: begin
            last_idx  = 2'd2;
            next_byte = (next_idx == 2'd1) ? 8'(cap_addr) : 8'(cap_data);
         end
         T_RD: begin
            next_byte = 8'(cap_addr);
         end
         T_ALU: begin
            last_idx = 2'd3;
            case (next_idx)
               2'd1:    next_byte = 8'(cap_opa);
               2'd2:    next_byte = 8'(cap_opb);
               default: next_byte = 8'(cap_fun);
            endcase
         end
         default: begin
            next_byte = 8'(cap_fun);
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
         byte_out    <= 8'h00;
         byte_valid  <= 1'b0;
         rsp_data    <= '0;
         rsp_done    <= 1'b0;
         rsp_timeout <= 1'b0;
         idx         <= 2'd0;
         rsp_cnt     <= 1'b0;
         to_cnt      <= '0;
         cap_type    <= T_WR;
         cap_addr    <= '0;
         cap_data    <= '0;
         cap_opa     <= '0;
         cap_opb     <= '0;
         cap_fun     <= '0;
      end else begin
         rsp_done    <= 1'b0;
         rsp_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cap_type   <= cmd_type;
                  cap_addr   <= cmd_addr;
                  cap_data   <= cmd_data;
                  cap_opa    <= cmd_opa;
                  cap_opb    <= cmd_opb;
                  cap_fun    <= cmd_fun;
                  idx        <= 2'd0;
                  byte_out   <= header(cmd_type);
                  byte_valid <= 1'b1;
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (byte_ready) begin
                  if (idx == last_idx) begin
                     byte_valid <= 1'b0;
                     byte_out   <= 8'h00;
                     // Writes carry no response, so they complete as soon as the frame is out.
                     if (cap_type == T_WR) begin
                        rsp_done  <= 1'b1;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                     end else begin
                        to_cnt  <= '0;
                        rsp_cnt <= 1'b0;
                        state   <= WAIT_RSP;
                     end
                  end else begin
                     idx      <= next_idx;
                     byte_out <= next_byte;
                  end
               end
            end
            WAIT_RSP: begin
               if (rsp_valid) begin
                  to_cnt <= '0;
                  if (cap_type == T_RD || rsp_cnt) begin
                     if (cap_type == T_RD) begin
                        rsp_data <= (2*DATA_WIDTH)'(rsp_byte);
                     end else begin
                        rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= DATA_WIDTH'(rsp_byte);
                     end
                     rsp_done  <= 1'b1;
                     cmd_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     rsp_data <= (2*DATA_WIDTH)'(rsp_byte);
                     rsp_cnt  <= 1'b1;
                  end
               end else if (to_cnt == TO_WIDTH'(TIMEOUT - 1)) begin
                  rsp_timeout <= 1'b1;
                  cmd_ready   <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sys_cmd_framer.sv
// Self-checking bench for sys_cmd_framer: directed and randomized commands compared
// against a frame/response model built from the command encoding rules.
module tb_sys_cmd_framer;

   localparam int TIMEOUT = 1024;
   localparam logic [1:0] T_WR  = 2'd0;
   localparam logic [1:0] T_RD  = 2'd1;
   localparam logic [1:0] T_ALU = 2'd2;
   localparam logic [1:0] T_NOP = 2'd3;

   logic        CLK = 1'b0;
   logic        RST;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_type;
   logic [3:0]  cmd_addr;
   logic [7:0]  cmd_data;
   logic [7:0]  cmd_opa;
   logic [7:0]  cmd_opb;
   logic [3:0]  cmd_fun;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_byte;
   logic [15:0] rsp_data;
   logic        rsp_done;
   logic        rsp_timeout;
   logic        busy;

   int checks = 0;
   int errors = 0;

   sys_cmd_framer #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT(TIMEOUT), .TO_WIDTH(11)
   ) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb),
      .cmd_fun(cmd_fun),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .rsp_valid(rsp_valid), .rsp_byte(rsp_byte), .rsp_data(rsp_data),
      .rsp_done(rsp_done), .rsp_timeout(rsp_timeout), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check_output({tag, "_byte_out"}, 32'(byte_out), 32'h0);
      check_output({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
      check_output({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
      check_output({tag, "_rsp_done"}, 32'(rsp_done), 32'd0);
      check_output({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
      check_output({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // mode: 0 = byte_ready always 1, 1 = toggling starting at 0, 2 = random
   task automatic apply_stimulus(input logic [1:0] t, input logic [3:0] addr,
                                 input logic [7:0] data, input logic [7:0] opa,
                                 input logic [7:0] opb, input logic [3:0] fun,
                                 input int mode, input bit stray);
      logic [7:0]  frame[$];
      logic [15:0] pre;
      logic        rdy;
      int          i;
      int          k;
      int          n;
      n = 0;
      while (!cmd_ready && n < 100) begin
         step();
         n++;
      end
      check_output("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      case (t)
         T_WR:    frame = '{8'hAA, {4'h0, addr}, data};
         T_RD:    frame = '{8'hBB, {4'h0, addr}};
         T_ALU:   frame = '{8'hCC, opa, opb, {4'h0, fun}};
         default: frame = '{8'hDD, {4'h0, fun}};
      endcase
      pre       = rsp_data;
      cmd_type  = t;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_opa   = opa;
      cmd_opb   = opb;
      cmd_fun   = fun;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      cmd_type  = 2'($urandom);
      cmd_addr  = 4'($urandom);
      cmd_data  = 8'($urandom);
      cmd_opa   = 8'($urandom);
      cmd_opb   = 8'($urandom);
      cmd_fun   = 4'($urandom);
      check_output("accept_no_done", 32'(rsp_done | rsp_timeout), 32'd0);
      i = 0;
      k = 0;
      while (i < frame.size() && k < 200) begin
         check_output("send_valid", 32'(byte_valid), 32'd1);
         check_output("send_byte", 32'(byte_out), 32'(frame[i]));
         check_output("send_cmd_ready", 32'(cmd_ready), 32'd0);
         check_output("send_busy", 32'(busy), 32'd1);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = k[0];
            default: rdy = ($urandom_range(0, 2) != 0);
         endcase
         byte_ready = rdy;
         if (stray) begin
            rsp_valid = 1'($urandom);
            rsp_byte  = 8'($urandom);
         end
         step();
         byte_ready = 1'b0;
         rsp_valid  = 1'b0;
         if (rdy) i++;
         k++;
      end
      check_output("send_complete", 32'(i), 32'(frame.size()));
      if (t == T_WR) begin
         check_output("wr_done", 32'(rsp_done), 32'd1);
         check_output("wr_rsp_data", 32'(rsp_data), 32'h0);
         check_output("wr_cmd_ready", 32'(cmd_ready), 32'd1);
         check_output("wr_busy", 32'(busy), 32'd0);
         check_output("wr_byte_valid", 32'(byte_valid), 32'd0);
         check_output("wr_no_timeout", 32'(rsp_timeout), 32'd0);
      end else begin
         check_output("wait_byte_valid", 32'(byte_valid), 32'd0);
         check_output("wait_busy", 32'(busy), 32'd1);
         check_output("wait_rsp_data_kept", 32'(rsp_data), 32'(pre));
         check_output("wait_no_done", 32'(rsp_done), 32'd0);
      end
   endtask

   task automatic idle_cycles(input int d);
      logic saw_pulse;
      saw_pulse = 1'b0;
      for (int c = 0; c < d; c++) begin
         step();
         if (rsp_done || rsp_timeout) saw_pulse = 1'b1;
      end
      check_output("idle_no_pulse", 32'(saw_pulse), 32'd0);
   endtask

   task automatic send_rsp(input logic [7:0] b);
      rsp_valid = 1'b1;
      rsp_byte  = b;
      step();
      rsp_valid = 1'b0;
      rsp_byte  = 8'($urandom);
   endtask

   task automatic check_done(input string tag, input logic [15:0] expected);
      check_output({tag, "_done"}, 32'(rsp_done), 32'd1);
      check_output({tag, "_data"}, 32'(rsp_data), 32'(expected));
      check_output({tag, "_no_timeout"}, 32'(rsp_timeout), 32'd0);
      check_output({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check_output({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_response(input logic [1:0] t, input logic [7:0] b0,
                                input logic [7:0] b1, input int d0, input int d1,
                                input bit to_first);
      int   n;
      logic saw_done;
      idle_cycles(d0);
      send_rsp(b0);
      if (t == T_RD) begin
         check_done("rd", {8'h00, b0});
      end else if (to_first) begin
         check_output("alu_first_no_done", 32'(rsp_done), 32'd0);
         n        = 0;
         saw_done = 1'b0;
         while (!rsp_timeout && n < TIMEOUT + 10) begin
            step();
            n++;
            if (rsp_done) saw_done = 1'b1;
         end
         check_output("timeout_latency", 32'(n), 32'(TIMEOUT));
         check_output("timeout_no_done", 32'(saw_done | rsp_done), 32'd0);
         check_output("timeout_partial", 32'(rsp_data[7:0]), 32'(b0));
         check_output("timeout_cmd_ready", 32'(cmd_ready), 32'd1);
         check_output("timeout_busy", 32'(busy), 32'd0);
      end else begin
         check_output("alu_first_no_done", 32'(rsp_done), 32'd0);
         idle_cycles(d1);
         send_rsp(b1);
         check_done("alu", {b1, b0});
      end
   endtask

   initial begin
      logic [15:0] pre;
      logic [1:0]  t;
      logic [7:0]  b0;
      logic [7:0]  b1;
      bit          to;
      RST        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_type   = 2'd0;
      cmd_addr   = 4'h0;
      cmd_data   = 8'h00;
      cmd_opa    = 8'h00;
      cmd_opb    = 8'h00;
      cmd_fun    = 4'h0;
      byte_ready = 1'b0;
      rsp_valid  = 1'b0;
      rsp_byte   = 8'h00;
      step();
      step();
      RST = 1'b0;
      check_reset_values("reset");

      $display("[TB] directed write");
      apply_stimulus(T_WR, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 1'b0);

      $display("[TB] directed ALU with operands, toggling ready");
      apply_stimulus(T_ALU, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 1, 1'b0);
      wait_response(T_ALU, 8'h46, 8'h00, 3, 2, 1'b0);

      $display("[TB] directed read with late response");
      apply_stimulus(T_RD, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1'b0);
      wait_response(T_RD, 8'hA7, 8'h00, 50, 0, 1'b0);

      $display("[TB] ALU without operands, partial response then timeout");
      apply_stimulus(T_NOP, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 0, 1'b0);
      wait_response(T_NOP, 8'h10, 8'h00, 4, 0, 1'b1);

      $display("[TB] reset mid-frame");
      step();
      cmd_type   = T_ALU;
      cmd_opa    = 8'h5A;
      cmd_opb    = 8'hC3;
      cmd_fun    = 4'h7;
      cmd_valid  = 1'b1;
      step();
      cmd_valid  = 1'b0;
      byte_ready = 1'b1;
      step();
      byte_ready = 1'b0;
      check_output("midframe_second_byte", 32'(byte_out), 32'h5A);
      RST = 1'b1;
      step();
      RST = 1'b0;
      check_reset_values("midframe_reset");
      apply_stimulus(T_WR, 4'hA, 8'h81, 8'h00, 8'h00, 4'h0, 2, 1'b0);

      $display("[TB] stray response bytes in IDLE and SEND");
      apply_stimulus(T_RD, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1'b0);
      wait_response(T_RD, 8'h6E, 8'h00, 1, 0, 1'b0);
      step();
      pre = rsp_data;
      send_rsp(8'hF0);
      check_output("stray_idle_data", 32'(rsp_data), 32'(pre));
      check_output("stray_idle_pulse", 32'(rsp_done | rsp_timeout), 32'd0);
      check_output("stray_idle_busy", 32'(busy), 32'd0);
      apply_stimulus(T_ALU, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3, 2, 1'b1);
      wait_response(T_ALU, 8'h03, 8'h80, 0, 0, 1'b0);

      $display("[TB] response in terminal-count cycle");
      apply_stimulus(T_RD, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1'b0);
      wait_response(T_RD, 8'h55, 8'h00, TIMEOUT - 1, 0, 1'b0);
      apply_stimulus(T_NOP, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF, 0, 1'b0);
      wait_response(T_NOP, 8'h11, 8'h22, 2, TIMEOUT - 1, 1'b0);

      $display("[TB] randomized back-to-back commands");
      for (int r = 0; r < 24; r++) begin
         t  = 2'($urandom);
         b0 = 8'($urandom);
         b1 = 8'($urandom);
         to = (t >= T_ALU) && ($urandom_range(0, 7) == 0);
         apply_stimulus(t, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                        4'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
         if (t != T_WR) begin
            wait_response(t, b0, b1, int'($urandom_range(0, 40)),
                          int'($urandom_range(0, 40)), to);
         end
      end

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sys_cmd_framer.md
Name: sys_cmd_framer

Overview:
- Host-side command framer that sits directly upstream of the system's UART RX input.
- Converts one structured command (register write, register read, ALU with operands, ALU without operands) into the byte frame the system controller parses.
- Presents the bytes to a host UART transmitter over a valid/ready byte stream.
- Collects the returned response bytes and reports the result, or a timeout if no response arrives.

Parameters:
- DATA_WIDTH, 8, byte / operand / register-data width.
- ADDR_WIDTH, 4, register-file address width; zero-extended into the address byte.
- FUN_WIDTH, 4, ALU function width; zero-extended into the function byte.
- TIMEOUT, 1024, idle cycles allowed between response bytes before aborting.
- TO_WIDTH, 11, timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  framer can accept a command.
- cmd_type  in  2  command select: 0 = WR, 1 = RD, 2 = ALU_OP, 3 = ALU_NOP.
- cmd_addr  in  ADDR_WIDTH  register address (WR, RD).
- cmd_data  in  DATA_WIDTH  write data (WR).
- cmd_opa  in  DATA_WIDTH  operand A (ALU_OP).
- cmd_opb  in  DATA_WIDTH  operand B (ALU_OP).
- cmd_fun  in  FUN_WIDTH  ALU function (ALU_OP, ALU_NOP).
- byte_out  out  8  frame byte to the host UART TX.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  host UART TX accepts byte_out.
- rsp_valid  in  1  response byte received from the host UART RX (one-cycle strobe).
- rsp_byte  in  8  response byte.
- rsp_data  out  2*DATA_WIDTH  assembled response.
- rsp_done  out  1  one-cycle pulse: command complete.
- rsp_timeout  out  1  one-cycle pulse: response timed out.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset, applied on any CLK edge with RST=1 (including mid-frame or mid-wait):
  - FSM returns to IDLE.
  - cmd_ready=1; byte_out=0, byte_valid=0, rsp_data=0, rsp_done=0, rsp_timeout=0, busy=0.
  - Byte index and timeout counter clear.
  - Any partial frame is dropped with no completion pulse.
- FSM states: IDLE, SEND, WAIT_RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, capture all cmd_* fields, clear byte index, go to SEND.
  - byte_valid rises the next cycle with byte 0.
- Frames, bytes sent in this order:
  - WR: 0xAA, addr, data.
  - RD: 0xBB, addr.
  - ALU_OP: 0xCC, opa, opb, fun.
  - ALU_NOP: 0xDD, fun.
- SEND:
  - byte_valid=1 and byte_out held stable until byte_valid & byte_ready.
  - Each handshake advances the index; the next byte is presented the following cycle (no bubble).
  - byte_ready is ignored when byte_valid=0.
- After the last byte's handshake:
  - WR: return to IDLE; rsp_done pulses in the next cycle and rsp_data is set to 0 in that same cycle.
  - RD: go to WAIT_RSP, expecting 1 response byte.
  - ALU_OP / ALU_NOP: go to WAIT_RSP, expecting 2 response bytes.
- WAIT_RSP:
  - Timeout counter clears on entry and on each accepted rsp byte; otherwise increments each cycle.
  - Response byte placement:
    - RD: rsp_data = {8'h00, byte}.
    - ALU: first byte is the LSB (rsp_data[7:0]); second byte is the MSB (rsp_data[15:8]).
  - Once the final expected byte is taken: rsp_done pulses in the next cycle with rsp_data valid, and the FSM returns to IDLE.
  - If the counter reaches TIMEOUT-1 with no rsp_valid that cycle: rsp_timeout pulses next cycle, FSM returns to IDLE, rsp_data keeps any partially captured bytes.
  - rsp_valid in the terminal-count cycle takes priority over timeout.
- rsp_valid is ignored in IDLE and SEND (stray bytes are discarded).
- cmd_ready=0 outside IDLE. A new command is accepted only in IDLE; the cycle carrying a done/timeout pulse is IDLE, so back-to-back acceptance is legal in that cycle.
- busy = (state != IDLE).
- rsp_done and rsp_timeout are never high together.

Test Plan:
- Reset, then WR addr=4'h5 data=8'h3C with byte_ready tied 1 -> byte_out AA,05,3C on 3 consecutive cycles; rsp_done 1 cycle after the 3C handshake; rsp_data=0.
- ALU_OP opa=8'h12 opb=8'h34 fun=4'h0, byte_ready toggling 1/0 -> bytes CC,12,34,00 each held stable while ready=0; then rsp bytes 46,00 -> rsp_done with rsp_data=16'h0046.
- RD addr=4'h2, rsp byte 8'hA7 after 50 cycles -> rsp_data=16'h00A7, rsp_done pulse, cmd_ready back to 1.
- ALU_NOP fun=4'h2, single rsp byte 8'h10 then silence -> rsp_timeout exactly TIMEOUT cycles after that byte; rsp_data[7:0]=10; no rsp_done.
- RST asserted during the 2nd byte of an ALU_OP frame -> next cycle all outputs at reset values; next command starts cleanly from byte 0.
- rsp_valid asserted in IDLE and during SEND -> ignored; rsp_data unchanged; no pulses.
